// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer for a Cortex-M0 style core.
// Runs the reset-vector load (SP then PC), then loops FETCH/DECODE/EXEC/MEM.
// Each memory phase has a bounded wait; if it runs out, the block enters a
// sticky FAULT state.
//
// Ports:
//   clk, rst_n              core clock (posedge), async active-low reset
//   start_i                 leave IDLE (vector load) or leave HALT
//   halt_req_i              halt request, sampled on the first FETCH cycle
//   mem_ready_i             memory completes the current read/write
//   dec_*_i                 decoder fields, latched during DECODE
//   cu_rd_mem_o/cu_wr_mem_o memory read/write requests
//   cu_decode_o             decode strobe
//   ld_*_o                  register / PSR / PRIMASK load strobes
//   fault_o                 sticky bus-timeout fault
//   state_o                 current state encoding
//   cycle_count_o           active cycles (saturating)
//   instr_count_o           retired instructions (wrapping)
//
// The strobes ld_sp_o and ld_pc_o (vector phase) fire in the cycle in which
// mem_ready_i completes the read. They are therefore qualified by that input.
// cu_rd_mem_o on the first FETCH cycle is qualified by halt_req_i. All other
// outputs are decodes of registered state.
module cu_sequencer #(
  parameter int unsigned EXW          = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             halt_req_i,
  input  logic             mem_ready_i,
  input  logic [EXW-1:0]   dec_exec_cycles_i,
  input  logic             dec_wr_rd_i,
  input  logic             dec_wr_apsr_i,
  input  logic             dec_branch_i,
  input  logic             dec_link_i,
  input  logic             dec_set_primask_i,
  input  logic             dec_mem_wr_i,
  output logic             cu_rd_mem_o,
  output logic             cu_wr_mem_o,
  output logic             cu_decode_o,
  output logic             ld_sp_o,
  output logic             ld_lr_o,
  output logic             ld_pc_o,
  output logic             ld_rd_o,
  output logic             ld_apsr_o,
  output logic             ld_ipsr_o,
  output logic             ld_primask_o,
  output logic             fault_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instr_count_o
);

  // wait_q never exceeds WAIT_TIMEOUT-1 because the limit cycle always leaves the state
  localparam int unsigned WAIT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_VEC_SP = 4'd1;
  localparam logic [3:0] S_VEC_PC = 4'd2;
  localparam logic [3:0] S_FETCH  = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_MEM    = 4'd6;
  localparam logic [3:0] S_HALT   = 4'd7;
  localparam logic [3:0] S_FAULT  = 4'd8;

  logic [3:0]        state_q, state_d;
  logic              entry_q, entry_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [EXW-1:0]    exec_q, exec_d;
  logic              wr_rd_q, wr_apsr_q, branch_q, link_q, primask_q, mem_wr_q;
  logic              wr_rd_d, wr_apsr_d, branch_d, link_d, primask_d, mem_wr_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d;

  logic halt_now, mem_wait, timeout, exec_last, active, retire;

  // Shared qualifiers
  assign halt_now  = (state_q == S_FETCH) && entry_q && halt_req_i;
  assign mem_wait  = (state_q == S_VEC_SP) || (state_q == S_VEC_PC) || (state_q == S_MEM) ||
                     ((state_q == S_FETCH) && !halt_now);
  assign timeout   = mem_wait && !mem_ready_i && (wait_q == WAIT_W'(WAIT_TIMEOUT - 1));
  assign exec_last = (state_q == S_EXEC) && (exec_q == EXW'(1));
  assign active    = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
  assign retire    = (state_d == S_FETCH) && ((state_q == S_EXEC) || (state_q == S_MEM));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Next-state logic; completion takes priority over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_VEC_SP;
      S_VEC_SP: if (mem_ready_i) state_d = S_VEC_PC;
                else if (timeout) state_d = S_FAULT;
      S_VEC_PC: if (mem_ready_i) state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
      S_FETCH:  if (halt_now) state_d = S_HALT;
                else if (mem_ready_i) state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (exec_last) state_d = mem_wr_q ? S_MEM : S_FETCH;
      S_MEM:    if (mem_ready_i) state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
      S_HALT:   if (start_i) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    entry_d = (state_d != state_q);
  end

  // Output decode
  always_comb begin
    cu_rd_mem_o  = 1'b0;
    cu_wr_mem_o  = 1'b0;
    cu_decode_o  = 1'b0;
    ld_sp_o      = 1'b0;
    ld_lr_o      = 1'b0;
    ld_pc_o      = 1'b0;
    ld_rd_o      = 1'b0;
    ld_apsr_o    = 1'b0;
    ld_ipsr_o    = 1'b0;
    ld_primask_o = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      S_VEC_SP: begin
        cu_rd_mem_o = 1'b1;
        ld_sp_o     = mem_ready_i;
      end
      S_VEC_PC: begin
        cu_rd_mem_o = 1'b1;
        ld_pc_o     = mem_ready_i;
      end
      S_FETCH:  cu_rd_mem_o = !halt_now;
      S_DECODE: cu_decode_o = 1'b1;
      S_EXEC: begin
        ld_rd_o      = exec_last && wr_rd_q;
        ld_apsr_o    = exec_last && wr_apsr_q;
        ld_primask_o = exec_last && primask_q;
        ld_pc_o      = exec_last && branch_q;
        ld_lr_o      = exec_last && branch_q && link_q;
      end
      S_MEM:    cu_wr_mem_o = 1'b1;
      S_FAULT: begin
        fault_o   = 1'b1;
        ld_ipsr_o = entry_q;
      end
      default: ;
    endcase
  end

  // Datapath next values: wait timer, execute counter, decode latch, counters
  always_comb begin
    wait_d    = wait_q;
    exec_d    = exec_q;
    wr_rd_d   = wr_rd_q;
    wr_apsr_d = wr_apsr_q;
    branch_d  = branch_q;
    link_d    = link_q;
    primask_d = primask_q;
    mem_wr_d  = mem_wr_q;
    cyc_d     = cyc_q;
    ins_d     = ins_q;

    if (state_d != state_q) wait_d = '0;
    else if (mem_wait && !mem_ready_i) wait_d = wait_q + WAIT_W'(1);

    if (state_q == S_DECODE) begin
      exec_d    = (dec_exec_cycles_i == '0) ? EXW'(1) : dec_exec_cycles_i;
      wr_rd_d   = dec_wr_rd_i;
      wr_apsr_d = dec_wr_apsr_i;
      branch_d  = dec_branch_i;
      link_d    = dec_link_i;
      primask_d = dec_set_primask_i;
      mem_wr_d  = dec_mem_wr_i;
    end else if ((state_q == S_EXEC) && !exec_last) begin
      exec_d = exec_q - EXW'(1);
    end

    if (active && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
    if (retire) ins_d = ins_q + CNT_W'(1);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      exec_q    <= '0;
      wr_rd_q   <= 1'b0;
      wr_apsr_q <= 1'b0;
      branch_q  <= 1'b0;
      link_q    <= 1'b0;
      primask_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      wait_q    <= wait_d;
      exec_q    <= exec_d;
      wr_rd_q   <= wr_rd_d;
      wr_apsr_q <= wr_apsr_d;
      branch_q  <= branch_d;
      link_q    <= link_d;
      primask_q <= primask_d;
      mem_wr_q  <= mem_wr_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign state_o       = state_q;
  assign cycle_count_o = cyc_q;
  assign instr_count_o = ins_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Testbench for cu_sequencer. It builds the expected per-cycle output vector
// from the instruction-level phase rules and queues it. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs.
module tb_cu_sequencer;

  localparam int unsigned EXW = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WAIT_TIMEOUT = 15;

  localparam logic [3:0] IDLE = 4'd0, VEC_SP = 4'd1, VEC_PC = 4'd2, FETCH = 4'd3,
                         DECODE = 4'd4, EXEC = 4'd5, MEM = 4'd6, HALT = 4'd7, FAULT = 4'd8;

  // strobe bits in observation order
  localparam logic [10:0] RD = 11'h400, WR = 11'h200, DEC = 11'h100, SP = 11'h080,
                          LR = 11'h040, PC = 11'h020, RDW = 11'h010, APSR = 11'h008,
                          IPSR = 11'h004, PRIM = 11'h002, FLT = 11'h001, NONE = 11'h000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic [EXW-1:0] dec_exec_cycles = '0;
  logic dec_wr_rd = 1'b0, dec_wr_apsr = 1'b0, dec_branch = 1'b0, dec_link = 1'b0;
  logic dec_set_primask = 1'b0, dec_mem_wr = 1'b0;
  logic cu_rd_mem, cu_wr_mem, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask, fault;
  logic [3:0] state;
  logic [CNT_W-1:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  cu_sequencer #(.EXW(EXW), .CNT_W(CNT_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .halt_req_i(halt_req), .mem_ready_i(mem_ready),
    .dec_exec_cycles_i(dec_exec_cycles), .dec_wr_rd_i(dec_wr_rd), .dec_wr_apsr_i(dec_wr_apsr),
    .dec_branch_i(dec_branch), .dec_link_i(dec_link), .dec_set_primask_i(dec_set_primask),
    .dec_mem_wr_i(dec_mem_wr), .cu_rd_mem_o(cu_rd_mem), .cu_wr_mem_o(cu_wr_mem),
    .cu_decode_o(cu_decode), .ld_sp_o(ld_sp), .ld_lr_o(ld_lr), .ld_pc_o(ld_pc), .ld_rd_o(ld_rd),
    .ld_apsr_o(ld_apsr), .ld_ipsr_o(ld_ipsr), .ld_primask_o(ld_primask), .fault_o(fault),
    .state_o(state), .cycle_count_o(cycle_count), .instr_count_o(instr_count)
  );

  logic [22:0] obs;
  assign obs = {cu_rd_mem, cu_wr_mem, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr,
                ld_ipsr, ld_primask, fault, state, cycle_count, instr_count};

  logic [22:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic stim_done = 1'b0;

  // reference bookkeeping
  int act = 0;
  int ret = 0;
  logic [EXW-1:0] i_ex;
  logic [5:0] i_f; // {mem_wr, set_primask, link, branch, wr_apsr, wr_rd}

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int lat();
    return ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
  endfunction

  // One clock of stimulus plus its expected outputs
  task automatic step(input logic [3:0] st, input logic [10:0] strb, input logic s,
                      input logic hr, input logic mr);
    logic [3:0] cexp;
    @(posedge clk); #1;
    start = s; halt_req = hr; mem_ready = mr;
    if (st == DECODE) begin
      dec_exec_cycles = i_ex; dec_wr_rd = i_f[0]; dec_wr_apsr = i_f[1]; dec_branch = i_f[2];
      dec_link = i_f[3]; dec_set_primask = i_f[4]; dec_mem_wr = i_f[5];
    end else begin
      dec_exec_cycles = EXW'($urandom); dec_wr_rd = rb(); dec_wr_apsr = rb(); dec_branch = rb();
      dec_link = rb(); dec_set_primask = rb(); dec_mem_wr = rb();
    end
    cexp = (act > 15) ? 4'hF : 4'(act);
    exp_q.push_back({strb, st, cexp, 4'(ret)});
    if (st != IDLE && st != HALT && st != FAULT) act++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; act = 0; ret = 0;
    exp_q.push_back('0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      start = rb(); halt_req = rb(); mem_ready = rb();
      exp_q.push_back('0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    exp_q.push_back('0);
  endtask

  // Memory phase completing after lt not-ready cycles
  task automatic wait_phase(input logic [3:0] st, input logic [10:0] req, input logic [10:0] done,
                            input int lt);
    for (int i = 0; i <= lt; i++)
      step(st, (i == lt) ? (req | done) : req, rb(), (i == 0) ? 1'b0 : rb(), (i == lt));
  endtask

  // Memory phase that never completes: limit reached, then sticky fault
  task automatic timeout_phase(input logic [3:0] st, input logic [10:0] req);
    for (int i = 0; i < int'(WAIT_TIMEOUT); i++)
      step(st, req, rb(), (i == 0) ? 1'b0 : rb(), 1'b0);
    step(FAULT, IPSR | FLT, rb(), rb(), rb());
    for (int i = 0; i < 4; i++) step(FAULT, FLT, 1'b1, rb(), rb());
  endtask

  task automatic vec_load(input int lsp, input int lpc);
    step(IDLE, NONE, 1'b1, rb(), rb());
    wait_phase(VEC_SP, RD, SP, lsp);
    wait_phase(VEC_PC, RD, PC, lpc);
  endtask

  // One instruction; lm < 0 means the store never completes
  task automatic instr(input logic [EXW-1:0] ex, input logic [5:0] f, input int lf, input int lm);
    int n;
    logic [10:0] fin;
    i_ex = ex; i_f = f;
    wait_phase(FETCH, RD, NONE, lf);
    step(DECODE, DEC, rb(), rb(), rb());
    n = (ex == 0) ? 1 : int'(ex);
    for (int i = 1; i < n; i++) step(EXEC, NONE, rb(), rb(), rb());
    fin = (f[0] ? RDW : NONE) | (f[1] ? APSR : NONE) | (f[2] ? PC : NONE) |
          ((f[2] && f[3]) ? LR : NONE) | (f[4] ? PRIM : NONE);
    step(EXEC, fin, rb(), rb(), rb());
    if (f[5]) begin
      if (lm < 0) begin
        timeout_phase(MEM, WR);
        return;
      end
      wait_phase(MEM, WR, NONE, lm);
    end
    ret++;
  endtask

  task automatic halt_seq(input int k);
    step(FETCH, NONE, rb(), 1'b1, rb());
    for (int i = 0; i < k; i++) step(HALT, NONE, 1'b0, rb(), rb());
    step(HALT, NONE, 1'b1, 1'b1, rb());
  endtask

  // Monitor: compare every queued expectation against the DUT
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        begin
          errors++;
          $display("FAIL outputs t=%0t got strb=%h st=%0d cyc=%0d ins=%0d exp strb=%h st=%0d cyc=%0d ins=%0d",
                   $time, obs[22:12], obs[11:8], obs[7:4], obs[3:0], e[22:12], e[11:8], e[7:4], e[3:0]);
        end
    end
    if (stim_done) begin
      if (checks == 0) $display("FAIL no checks were performed");
      if (errors != 0) $display("FAIL %0d mismatches", errors);
      else $display("PASS");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset(3);
    vec_load(0, 0);
    instr(3'd3, 6'b000011, 0, 0);
    instr(3'd0, 6'b000000, 0, 0);
    instr(3'd2, 6'b101100, 1, 4);
    instr(3'd7, 6'b010001, 14, 0);
    halt_seq(3);
    instr(3'd1, 6'b000101, 2, 14);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) halt_seq(int'($urandom_range(0, 3)));
      instr(EXW'($urandom), 6'($urandom), lat(), lat());
    end
    // asynchronous reset in the middle of a long execute
    i_ex = 3'd5; i_f = 6'b000011;
    wait_phase(FETCH, RD, NONE, 0);
    step(DECODE, DEC, rb(), rb(), rb());
    step(EXEC, NONE, rb(), rb(), rb());
    step(EXEC, NONE, rb(), rb(), rb());
    do_reset(2);
    vec_load(lat(), lat());
    for (int k = 0; k < 3; k++) instr(EXW'($urandom), 6'($urandom), lat(), lat());
    instr(3'd2, 6'b100000, 0, -1);
    do_reset(2);
    vec_load(1, 2);
    for (int k = 0; k < 2; k++) instr(EXW'($urandom), 6'($urandom), lat(), lat());
    timeout_phase(FETCH, RD);
    do_reset(1);
    if (state !== IDLE || fault !== 1'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL post-reset state=%0d fault=%b ins=%0d", state, fault, instr_count);
    end
    stim_done = 1'b1;
  end

endmodule
